// File: rtl/ram_burst_reader_pkg.sv
// Shared types for the burst reader: FSM encoding and buffer sizing.
// Imported by the interface, the skid FIFO and the top level.
package ram_burst_reader_pkg;

  // Reader FSM: idle waits for a request, read walks the RAM.
  typedef enum logic {
    StIdle = 1'b0,
    StRead = 1'b1
  } state_e;

  localparam int unsigned FifoDepth = 2;

  typedef logic [1:0] fifo_cnt_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Request, RAM read port and output stream of the burst reader.
// The slave modport is the reader itself; master is the surrounding system.
interface ram_burst_reader_if
  import ram_burst_reader_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned LWIDTH = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [AWIDTH-1:0] req_addr;
  logic [LWIDTH-1:0] req_len;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_q;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_len, ram_q, out_ready,
    input  req_ready, ram_addr, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  req_valid, req_addr, req_len, ram_q, out_ready,
    output req_ready, ram_addr, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/ram_burst_reader_burst_skid_fifo2.sv
// Two-entry FIFO whose head register drives the consumer directly, so the
// output valid/data are registered and independent of the pop request.
module burst_skid_fifo2
  import ram_burst_reader_pkg::*;
#(
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             valid,
  output fifo_cnt_t        count
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  fifo_cnt_t        count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = din;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = din;
        end else if (push) begin
          tail_d  = din;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = din;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

  // A full buffer may only accept a word in the same cycle it releases one.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == fifo_cnt_t'(FifoDepth))));

  assert property (@(posedge clk) disable iff (rst) !(pop && (count_q == 2'd0)));

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: accepts {base, len}, walks consecutive RAM addresses
// and streams the words out through a 2-entry skid buffer with a last flag.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned LWIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  ram_burst_reader_if.slave bus
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [LWIDTH-1:0] remain_q, remain_d;

  logic              req_fire;
  logic              out_fire;
  logic              rd_fire;
  logic              fifo_valid;
  logic [DWIDTH:0]   fifo_din;
  logic [DWIDTH:0]   fifo_head;
  fifo_cnt_t         fifo_count;

  assign req_fire = bus.req_valid && (state_q == StIdle);
  assign out_fire = fifo_valid && bus.out_ready;
  // A read may issue into a full buffer only when the head leaves this cycle.
  assign rd_fire  = (state_q == StRead) &&
                    ((fifo_count != fifo_cnt_t'(FifoDepth)) || out_fire);

  assign fifo_din = {bus.ram_q, (remain_q == '0)};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          addr_d   = bus.req_addr;
          remain_d = bus.req_len;
          state_d  = StRead;
        end
      end
      StRead: begin
        if (rd_fire) begin
          addr_d   = addr_q + AWIDTH'(1);
          remain_d = remain_q - LWIDTH'(1);
          if (remain_q == '0) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  burst_skid_fifo2 #(
    .Width (DWIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_fire),
    .din   (fifo_din),
    .pop   (out_fire),
    .dout  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign bus.ram_addr  = addr_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_head[DWIDTH:1];
  assign bus.out_last  = fifo_head[0];
  assign bus.busy      = (state_q == StRead) || (fifo_count != 2'd0);

  assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_last)));

endmodule
